// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: RV32I B-type compare, redirect target and mispredict flag,
// 1- or 2-stage valid/ready pipeline with flush and saturating retire statistics.
module branch_resolve_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             cnt_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic             out_eq,
  output logic             out_lt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (XLEN < 8) begin : g_bad_xlen
    $error("branch_resolve_unit: XLEN must be at least 8");
  end

  // Mode decode and compare on the raw execute operands
  logic d_eq, d_lt_s, d_lt_u, d_lt, d_taken, d_illegal;

  always_comb begin
    d_eq      = (in_a == in_b);
    d_lt_s    = ($signed(in_a) < $signed(in_b));
    d_lt_u    = (in_a < in_b);
    d_lt      = d_lt_s;
    d_taken   = 1'b0;
    d_illegal = 1'b0;
    case (in_funct3)
      3'b000:  d_taken = d_eq;
      3'b001:  d_taken = ~d_eq;
      3'b100:  d_taken = d_lt_s;
      3'b101:  d_taken = ~d_lt_s;
      3'b110: begin
        d_lt    = d_lt_u;
        d_taken = d_lt_u;
      end
      3'b111: begin
        d_lt    = d_lt_u;
        d_taken = ~d_lt_u;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic retire, last_adv;
  assign retire   = out_valid & out_ready;
  assign last_adv = ~out_valid | out_ready;

  // Entry presented to the output register this cycle
  logic            src_valid;
  logic            src_taken;
  logic [XLEN-1:0] src_target;
  logic            src_mispredict;
  logic            src_eq;
  logic            src_lt;
  logic            src_illegal;

  if (STAGES == 1) begin : g_one
    assign in_ready       = last_adv & ~flush;
    assign src_valid      = in_valid & in_ready;
    assign src_taken      = d_taken;
    assign src_target     = d_taken ? (in_pc + in_imm) : (in_pc + PC_STEP);
    assign src_mispredict = (d_taken != in_pred_taken) | d_illegal;
    assign src_eq         = d_eq;
    assign src_lt         = d_lt;
    assign src_illegal    = d_illegal;
  end else if (STAGES == 2) begin : g_two
    logic            s1_valid;
    logic            s1_eq, s1_lt, s1_illegal, s1_taken, s1_pred;
    logic [XLEN-1:0] s1_pc, s1_imm;
    logic            s1_adv;

    assign s1_adv   = ~s1_valid | last_adv;
    assign in_ready = s1_adv & ~flush;

    // Stage 1 holds the compare result; the adder is deferred to stage 2
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1_valid   <= 1'b0;
        s1_eq      <= 1'b0;
        s1_lt      <= 1'b0;
        s1_illegal <= 1'b0;
        s1_taken   <= 1'b0;
        s1_pred    <= 1'b0;
        s1_pc      <= '0;
        s1_imm     <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_eq      <= d_eq;
          s1_lt      <= d_lt;
          s1_illegal <= d_illegal;
          s1_taken   <= d_taken;
          s1_pred    <= in_pred_taken;
          s1_pc      <= in_pc;
          s1_imm     <= in_imm;
        end
      end
    end

    assign src_valid      = s1_valid;
    assign src_taken      = s1_taken;
    assign src_target     = s1_taken ? (s1_pc + s1_imm) : (s1_pc + PC_STEP);
    assign src_mispredict = (s1_taken != s1_pred) | s1_illegal;
    assign src_eq         = s1_eq;
    assign src_lt         = s1_lt;
    assign src_illegal    = s1_illegal;
  end else begin : g_bad_stages
    $error("branch_resolve_unit: STAGES must be 1 or 2");
  end

  // Output register; payload only loads with a valid entry so it holds under stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_mispredict <= 1'b0;
      out_eq         <= 1'b0;
      out_lt         <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (last_adv) begin
      out_valid <= src_valid;
      if (src_valid) begin
        out_taken      <= src_taken;
        out_target     <= src_target;
        out_mispredict <= src_mispredict;
        out_eq         <= src_eq;
        out_lt         <= src_lt;
        out_illegal    <= src_illegal;
      end
    end
  end

  // Saturating retire statistics; a retire in a flush cycle still counts
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      taken_count   <= '0;
      mispred_count <= '0;
    end else if (cnt_clr) begin
      taken_count   <= '0;
      mispred_count <= '0;
    end else if (retire) begin
      if (out_taken && (taken_count != CNT_MAX)) begin
        taken_count <= taken_count + CNT_W'(1);
      end
      if (out_mispredict && (mispred_count != CNT_MAX)) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: a 1-stage/4-bit-counter unit and a 2-stage/16-bit-counter unit
// share stimulus; each keeps its own expected-response queue and counter model.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic        eq;
    logic        lt;
    logic        illegal;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, flush, cnt_clr, in_valid, out_ready, in_pred_taken;
  logic [2:0]  in_funct3;
  logic [31:0] in_a, in_b, in_pc, in_imm;

  logic        rdy1, ov1, tk1, mp1, eq1, lt1, il1;
  logic [31:0] tg1;
  logic [3:0]  tc1, mc1;
  logic        rdy2, ov2, tk2, mp2, eq2, lt2, il2;
  logic [31:0] tg2;
  logic [15:0] tc2, mc2;

  branch_resolve_unit #(.XLEN(32), .STAGES(1), .CNT_W(4)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(rdy1), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .out_valid(ov1), .out_ready(out_ready),
    .out_taken(tk1), .out_target(tg1), .out_mispredict(mp1), .out_eq(eq1),
    .out_lt(lt1), .out_illegal(il1), .taken_count(tc1), .mispred_count(mc1));

  branch_resolve_unit #(.XLEN(32), .STAGES(2), .CNT_W(16)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(rdy2), .in_funct3(in_funct3),
    .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .out_valid(ov2), .out_ready(out_ready),
    .out_taken(tk2), .out_target(tg2), .out_mispredict(mp2), .out_eq(eq2),
    .out_lt(lt2), .out_illegal(il2), .taken_count(tc2), .mispred_count(mc2));

  int n_checks = 0;
  int n_err    = 0;
  exp_t q0[$];
  exp_t q1[$];
  int m_tc[2];
  int m_mc[2];
  int cmax[2] = '{15, 65535};

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, id, act, exp, $time);
    end
  endtask

  // Reference: branch semantics straight from the ISA rules
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    exp_t e;
    logic slt, ult;
    slt       = ($signed(a) < $signed(b));
    ult       = (a < b);
    e.eq      = (a == b);
    e.lt      = slt;
    e.illegal = 1'b0;
    e.taken   = 1'b0;
    case (f3)
      3'd0: e.taken = e.eq;
      3'd1: e.taken = !e.eq;
      3'd4: e.taken = slt;
      3'd5: e.taken = !slt;
      3'd6: begin e.lt = ult; e.taken = ult;  end
      3'd7: begin e.lt = ult; e.taken = !ult; end
      default: e.illegal = 1'b1;
    endcase
    e.target = e.taken ? (pc + imm) : (pc + 32'd4);
    e.misp   = (e.taken != pred) || e.illegal;
    return e;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int id);
    if (id == 0) void'(q0.pop_front());
    else         void'(q1.pop_front());
  endtask

  task automatic qclear();
    q0.delete();
    q1.delete();
  endtask

  // Monitor: checks counters each cycle, payload against queue head whenever valid
  task automatic mon(input int id, input logic ov, input exp_t act, input int tc, input int mc);
    exp_t e;
    logic ret;
    e   = '0;
    ret = 1'b0;
    chk("taken_count", id, 64'(tc), 64'(m_tc[id]));
    chk("mispred_count", id, 64'(mc), 64'(m_mc[id]));
    if (ov) begin
      if (qsize(id) == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL spurious_output dut%0d: got valid entry 0x%0h expected none at %0t", id, act, $time);
      end else begin
        e = qfront(id);
        chk("payload", id, 64'(act), 64'(e));
        if (out_ready) begin
          qpop(id);
          ret = 1'b1;
        end
      end
    end
    if (cnt_clr) begin
      m_tc[id] = 0;
      m_mc[id] = 0;
    end else if (ret) begin
      if (e.taken && m_tc[id] < cmax[id]) m_tc[id]++;
      if (e.misp  && m_mc[id] < cmax[id]) m_mc[id]++;
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      mon(0, ov1, exp_t'({tk1, tg1, mp1, eq1, lt1, il1}), int'(tc1), int'(mc1));
      mon(1, ov2, exp_t'({tk2, tg2, mp2, eq2, lt2, il2}), int'(tc2), int'(mc2));
    end
  end

  // One cycle: after the monitor at negedge, check in_ready and record handshakes
  task automatic step();
    logic r, er;
    @(negedge clock);
    #1;
    for (int id = 0; id < 2; id++) begin
      r  = (id == 0) ? rdy1 : rdy2;
      er = !flush && ((qsize(id) < id + 1) || out_ready);
      chk("in_ready", id, 64'(r), 64'(er));
      if (in_valid && r && !flush) begin
        if (id == 0) q0.push_back(model(in_funct3, in_a, in_b, in_pc, in_imm, in_pred_taken));
        else         q1.push_back(model(in_funct3, in_a, in_b, in_pc, in_imm, in_pred_taken));
      end
    end
    if (flush) qclear();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    in_valid      = 1'b1;
    in_funct3     = f3;
    in_a          = a;
    in_b          = b;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
    step();
    in_valid = 1'b0;
  endtask

  task automatic reset_check();
    chk("reset_out1", 0, 64'({ov1, tk1, tg1, mp1, eq1, lt1, il1}), 64'(0));
    chk("reset_cnt1", 0, 64'({tc1, mc1}), 64'(0));
    chk("reset_out2", 1, 64'({ov2, tk2, tg2, mp2, eq2, lt2, il2}), 64'(0));
    chk("reset_cnt2", 1, 64'({tc2, mc2}), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] modes[4];
    logic       pat[4];
    logic [31:0] r;
    modes = '{3'd0, 3'd1, 3'd5, 3'd7};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    m_tc  = '{0, 0};
    m_mc  = '{0, 0};
    reset_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_a = '0; in_b = '0; in_pc = '0; in_imm = '0; in_pred_taken = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    reset_check();
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 0, 64'(rdy1), 64'(1));
    chk("ready_after_reset", 1, 64'(rdy2), 64'(1));

    // BLT signed vs BLTU unsigned on the same operands; latency 1 vs 2
    issue(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
    chk("blt_lat1", 0, 64'(ov1), 64'(1));
    chk("blt_target", 0, 64'(tg1), 64'(32'h120));
    chk("blt_lat1", 1, 64'(ov2), 64'(0));
    step();
    chk("blt_lat2", 0, 64'(ov1), 64'(0));
    chk("blt_lat2", 1, 64'(ov2), 64'(1));
    step();
    issue(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0);
    chk("bltu_target", 0, 64'(tg1), 64'(32'h104));
    chk("bltu_taken", 0, 64'({tk1, mp1, lt1}), 64'(0));
    step();
    chk("bltu_lat2", 1, 64'(ov2), 64'(1));
    step();

    // Back-to-back entries under a stalling consumer
    for (int i = 0; i < 4; i++) begin
      in_valid      = 1'b1;
      in_funct3     = modes[i];
      in_a          = 32'(i * 7);
      in_b          = (i % 2 == 0) ? 32'(i * 7) : 32'hFFFF_FFF0;
      in_pc         = 32'h1000 + 32'(i * 4);
      in_imm        = 32'hFFFF_FF00;
      in_pred_taken = 1'(i);
      out_ready     = pat[i];
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Illegal mode and PC wrap-around
    issue(3'b011, 32'd5, 32'd7, 32'h200, 32'h40, 1'b1);
    chk("illegal_flags", 0, 64'({tk1, il1, mp1}), 64'(3'b011));
    chk("illegal_target", 0, 64'(tg1), 64'(32'h204));
    issue(3'b001, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h10, 1'b0);
    chk("wrap_target", 0, 64'(tg1), 64'(0));
    repeat (2) step();

    // Flush with the 2-stage unit full and a coincident input
    out_ready = 1'b0;
    issue(3'b000, 32'd1, 32'd1, 32'h300, 32'h8, 1'b0);
    issue(3'b001, 32'd1, 32'd2, 32'h304, 32'h8, 1'b1);
    flush = 1'b1;
    in_valid = 1'b1;
    in_funct3 = 3'b000; in_a = 32'd3; in_b = 32'd3; in_pc = 32'h400;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", 0, 64'(ov1), 64'(0));
    chk("flush_valid", 1, 64'(ov2), 64'(0));
    step();
    chk("flush_dropped", 1, 64'(ov2), 64'(0));

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid      = ($urandom % 10) < 7;
      in_funct3     = 3'($urandom);
      in_a          = $urandom;
      r             = $urandom;
      case (r % 4)
        0: in_b = in_a;
        1: in_b = in_a ^ 32'h8000_0000;
        default: in_b = $urandom;
      endcase
      in_pc         = $urandom;
      in_imm        = $urandom;
      in_pred_taken = 1'($urandom);
      out_ready     = ($urandom % 10) < 7;
      flush         = ($urandom % 40) == 0;
      cnt_clr       = ($urandom % 50) == 0;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    repeat (4) step();

    // Saturation of the 4-bit counters
    repeat (20) issue(3'b000, 32'd42, 32'd42, 32'h500, 32'h10, 1'b0);
    repeat (3) step();
    chk("sat_taken", 0, 64'(tc1), 64'(15));
    chk("sat_mispred", 0, 64'(mc1), 64'(15));

    // Clear wins over a coincident retire
    issue(3'b000, 32'd1, 32'd1, 32'h600, 32'h10, 1'b0);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_retire", 0, 64'({tc1, mc1}), 64'(0));
    chk("clr_retire", 1, 64'({tc2, mc2}), 64'(0));
    repeat (2) step();

    // Asynchronous reset with entries in flight
    out_ready = 1'b0;
    issue(3'b100, 32'd1, 32'd2, 32'h700, 32'h10, 1'b0);
    issue(3'b101, 32'd1, 32'd2, 32'h704, 32'h10, 1'b1);
    reset_n = 1'b0;
    #1;
    reset_check();
    qclear();
    m_tc = '{0, 0};
    m_mc = '{0, 0};
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    // Drain: every accepted entry must have retired
    for (int c = 0; c < 20 && (qsize(0) + qsize(1)) != 0; c++) step();
    chk("drain_q", 0, 64'(qsize(0)), 64'(0));
    chk("drain_q", 1, 64'(qsize(1)), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the single-cycle branch comparator.
- Takes operands, funct3 mode, PC, immediate and predicted direction from execute.
- Produces a registered taken decision, redirect target and mispredict flag, with valid/ready flow control and flush.
- Keeps saturating taken and mispredict statistics counters for the performance monitor.

Parameters:
XLEN, 32, operand/PC/target width (>= 8)
STAGES, 1, pipeline depth, 1 or 2; any other value is a synthesis error
CNT_W, 16, width of statistics counters

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  kill all in-flight entries
cnt_clr  in  1  synchronous clear of both statistics counters
in_valid  in  1  input entry valid
in_ready  out  1  unit can accept input this cycle
in_funct3  in  3  branch mode (RV32I B-type funct3)
in_a  in  XLEN  rs1 value
in_b  in  XLEN  rs2 value
in_pc  in  XLEN  branch PC
in_imm  in  XLEN  sign-extended B-immediate
in_pred_taken  in  1  front-end predicted direction
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_taken  out  1  resolved direction
out_target  out  XLEN  next PC: in_pc+in_imm if taken, else in_pc+4
out_mispredict  out  1  out_taken != in_pred_taken, or out_illegal
out_eq  out  1  in_a == in_b
out_lt  out  1  in_a < in_b under mode signedness
out_illegal  out  1  funct3 010 or 011
taken_count  out  CNT_W  retired taken branches
mispred_count  out  CNT_W  retired mispredicts

Behaviour:
- Reset (reset_n low, asynchronous): all stage valids, out_* and both counters are 0. in_ready is 1 once reset_n is high.

Mode decode:
- 000 BEQ: taken = eq.
- 001 BNE: taken = !eq.
- 100 BLT: taken = lt, signed.
- 101 BGE: taken = !lt, signed.
- 110 BLTU: taken = lt, unsigned.
- 111 BGEU: taken = !lt, unsigned.
- 010 and 011: taken = 0 and illegal = 1.
- out_lt is signed for 10x and unsigned for 11x. For 00x and illegal modes, out_lt is the signed compare.

Arithmetic:
- Target sums are modulo 2^XLEN; carry-out is discarded. Wrap-around, e.g. pc = all-ones, is not an error.

Pipeline:
- STAGES=1: compare and target are computed combinationally and captured in one output register. Latency is 1 cycle from input handshake to out_valid.
- STAGES=2: stage 1 registers eq/lt/illegal/taken plus pc, imm and pred. Stage 2 registers target and mispredict. Latency is 2 cycles.
- A stage advances when it is empty or the downstream stage advances. The last stage advances on out_ready.
- in_ready = stage-1 empty OR stage-1 advancing. This is combinational from out_ready, with no bubble penalty, so full throughput is 1 entry/cycle.
- out_* payload holds stable while out_valid=1 and out_ready=0.

Flush:
- On a flush clock edge, all stage valids clear. Any in_valid in the same cycle is dropped.
- in_ready is forced to 0 while flush=1. An entry retiring in the flush cycle (out_valid & out_ready) still counts.

Counters:
- On retire (out_valid & out_ready): taken_count += out_taken, mispred_count += out_mispredict. Both saturate at 2^CNT_W-1.
- cnt_clr has priority over an increment in the same cycle; the counter becomes 0.

Reset mid-operation:
- Asserting reset_n low asynchronously drops all in-flight entries. No output pulses are generated.

Test Plan:
- STAGES=1, BLT, a=0xFFFFFFFF, b=1, pc=0x100, imm=0x20, pred=0, out_ready=1 -> next cycle out_valid=1, taken=1, lt=1, target=0x120, mispredict=1.
- Same operands with BLTU, pred=0 -> taken=0, lt=0, target=0x104, mispredict=0. Repeat with STAGES=2 -> response 2 cycles after handshake.
- Back-to-back BEQ/BNE/BGE/BGEU with out_ready toggled 1,0,0,1 -> no entry lost or duplicated; payload stable while stalled; in_ready low only when pipeline full and stalled.
- funct3=011, pred=1 -> taken=0, illegal=1, mispredict=1, target=pc+4. Also pc=0xFFFFFFFC not-taken -> target=0x00000000.
- STAGES=2 with 2 entries in flight, flush=1 with in_valid=1 -> next cycle out_valid=0, no counter change, dropped input never appears.
- CNT_W=4: retire 20 taken mispredicted branches -> both counters hold at 15. cnt_clr coincident with a retire -> counters 0. reset_n low mid-stream -> all outputs 0 immediately.
